rf_write_queue: RTL and testbench
=================================

Name: rf_write_queue

Overview:
- Write-back queue that sits directly upstream of the register-file write-enable decoder.
- Buffers pending register writes from the write-back stage and multi-cycle units (load returns, mult/div results).
- Drains them one per cycle as a single write strobe plus a 5-bit select and data; the decoder fans these out into per-register enables.
- Also provides a pending-write scoreboard and optional read forwarding, so decode can detect and resolve RAW hazards against queued writes.

Parameters:
- DATA_W, 32, width of register data.
- ADDR_W, 5, register select width (32 registers).
- DEPTH, 4, queue entries; power of two, ≥ 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all queued entries.
- in_valid  input  1  producer offers a write.
- in_ready  output  1  queue can accept this cycle.
- in_addr  input  ADDR_W  destination register.
- in_data  input  DATA_W  write data.
- rf_stall  input  1  register-file write port unavailable this cycle.
- rf_we  output  1  write strobe to the decoder's enable input.
- rf_waddr  output  ADDR_W  select to the decoder.
- rf_wdata  output  DATA_W  data to the register array.
- pend_mask  output  2**ADDR_W  bit r = 1 if any queued entry targets register r.
- count  output  $clog2(DEPTH)+1  occupancy.
- rd_addr  input  ADDR_W  forwarding lookup address (see Optional Feature).
- rd_hit  output  1  lookup matched a queued entry.
- rd_data  output  DATA_W  data of newest matching entry.

Behaviour:
- Storage: circular buffer, DEPTH entries of {addr, data}, with head/tail pointers and a count register.
- Reset (rst_n=0, async):
  - head = tail = count = 0; all entry valid state cleared.
  - Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, pend_mask=0, count=0, rd_hit=0, rd_data=0, in_ready=1 after deassertion.
  - Reset mid-drain discards all entries; no write is issued.
- Push:
  - Occurs when in_valid & in_ready.
  - in_ready = (count != DEPTH) & !flush. No pass-through when full, even if a pop happens the same cycle.
- Register 0:
  - Handshake completes but nothing is enqueued; count unchanged; pend_mask[0] is always 0.
- Drain:
  - rf_we = (count != 0) & !rf_stall & !flush.
  - rf_waddr/rf_wdata are driven combinationally from the head entry when count != 0, else 0.
  - Pop occurs on the same edge when rf_we=1.
- Latency:
  - Entry pushed at edge N is visible at head no earlier than after edge N. Minimum push-to-rf_we is 1 cycle (empty queue).
  - Writes drain in strict arrival order; one write per cycle maximum.
- Simultaneous push and pop: count unchanged, both pointers advance (mod DEPTH).
- Wrap-around: pointers wrap modulo DEPTH; ordering is preserved across the wrap.
- rf_stall=1: head is held; rf_we=0; pushes continue until full.
- flush:
  - Has priority over push and pop.
  - Next cycle: count=0 and pend_mask=0.
  - No rf_we is asserted in the flush cycle.
- pend_mask: combinational OR over valid entries of one-hot(addr). Duplicate addresses are allowed; the bit clears only when the last matching entry pops.
- count: registered; always equals the number of valid entries.

Optional Feature:
- Macro: RF_WRITE_QUEUE_FWD_EN.
- Defined:
  - rd_hit = (rd_addr != 0) & any valid entry has addr == rd_addr.
  - rd_data = data of the youngest such entry; 0 if no hit. Combinational.
- Not defined: rd_hit and rd_data are tied to 0 and the rd_addr input is ignored. Decode must stall on pend_mask instead.

Test Plan:
- Reset then single write: push (addr 5, 0xDEADBEEF) → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; cycle after, count=0 and pend_mask=0.
- Fill with rf_stall=1: push addrs 1,2,3,4 → count=4, in_ready=0, pend_mask=0x1E. Release stall → writes issue as 1,2,3,4 on four consecutive cycles.
- Wrap with concurrent push/pop: continuous push of addrs 1..10 while draining → 10 rf_we pulses in order, count never exceeds 2, no data loss.
- Register 0 and duplicates:
  - push addr 0 → accepted, count stays 0, no rf_we.
  - push addr 7 (0x11), then addr 7 (0x22) → pend_mask[7] stays 1 until the second pop.
  - With FWD_EN, rd_addr=7 returns 0x22.
- Flush: with 3 entries queued and in_valid=1, assert flush for 1 cycle → in_ready=0 and no rf_we in that cycle; next cycle count=0, pend_mask=0.
- Async reset mid-drain: assert rst_n=0 between edges with count=3 → rf_we, count and pend_mask go to 0 immediately; no write is issued after reset releases.

Source files
------------

// File: rtl/rf_write_queue.sv
// Register-file write-back queue: buffers pending writes, drains one per cycle to the
// write-enable decoder, and exposes a pending-write mask. Define RF_WRITE_QUEUE_FWD_EN for read forwarding.
module rf_write_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       rf_stall,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic [(1<<ADDR_W)-1:0]     pend_mask,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_hit,
  output logic [DATA_W-1:0]          rd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;
  logic               push, pop;

  assign in_ready = (count_q != CNT_W'(DEPTH)) && !flush;
  // Writes to r0 complete the handshake but are dropped; r0 is hard-wired.
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign rf_we    = (count_q != '0) && !rf_stall && !flush;
  assign pop      = rf_we;
  assign count    = count_q;
  assign rf_waddr = (count_q != '0) ? mem_q[head_q].addr : '0;
  assign rf_wdata = (count_q != '0) ? mem_q[head_q].data : '0;

  // NOTE: payload storage has no reset; valid_q alone decides what is live, so
  // stale payload is never observable and the array maps onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{addr: in_addr, data: in_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      // push and pop never hit the same slot: that needs count 0 or DEPTH,
      // where pop or push respectively is blocked.
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pend_mask[mem_q[i].addr] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

`ifdef RF_WRITE_QUEUE_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Scan oldest to youngest so the last match, the youngest entry, wins.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if (valid_q[fwd_idx] && (mem_q[fwd_idx].addr == rd_addr) && (rd_addr != '0)) begin
        rd_hit  = 1'b1;
        rd_data = mem_q[fwd_idx].data;
      end
    end
  end
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^rd_addr;
  assign rd_hit         = 1'b0;
  assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_rf_write_queue.sv
// Scoreboard bench for rf_write_queue: stimulus pushes expected writes, a negedge
// monitor pops and compares every rf_we pulse; directed checks cover occupancy/mask/flush/reset.
module tb_rf_write_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
`ifdef RF_WRITE_QUEUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_W-1:0]      in_addr;
  logic [DATA_W-1:0]      in_data;
  logic                   rf_stall;
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;
  logic [(1<<ADDR_W)-1:0] pend_mask;
  logic [$clog2(DEPTH):0] count;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   rd_hit;
  logic [DATA_W-1:0]      rd_data;

  rf_write_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .rf_stall(rf_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .count(count),
    .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drive_push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_t e;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    if (a != '0) begin
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
    end
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rf_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", rf_we, 0);
        end else begin
          e = exp_q.pop_front();
          check("drain_addr", rf_waddr, e.addr);
          check("drain_data", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    rf_stall = 1'b0; rd_addr = '0;

    // Reset state
    #2;
    check("rst_rf_we", rf_we, 0);
    check("rst_count", count, 0);
    check("rst_pend", pend_mask, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_rd_hit", rd_hit, 0);
    check("rst_rd_data", rd_data, 0);
    #10 rst_n = 1'b1;
    step();
    check("rst_in_ready", in_ready, 1);

    // Single write: rf_we one cycle after the push
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hDEADBEEF;
    exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
    at_neg();
    check("t1_in_ready", in_ready, 1);
    check("t1_pre_count", count, 0);
    check("t1_pre_we", rf_we, 0);
    step();
    in_valid = 1'b0;
    at_neg();
    check("t1_count", count, 1);
    check("t1_pend", pend_mask, 32'h0000_0020);
    check("t1_we", rf_we, 1);
    step();
    at_neg();
    check("t1_post_count", count, 0);
    check("t1_post_pend", pend_mask, 0);
    check("t1_post_we", rf_we, 0);

    // Fill under stall, then drain in order
    step();
    rf_stall = 1'b1;
    for (int a = 1; a <= 4; a++) drive_push(ADDR_W'(a), 32'h100 + a);
    at_neg();
    check("t2_count", count, 4);
    check("t2_in_ready", in_ready, 0);
    check("t2_pend", pend_mask, 32'h0000_001E);
    check("t2_we_stalled", rf_we, 0);
    step();
    in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h999;
    at_neg();
    check("t2_full_ready", in_ready, 0);
    step();
    in_valid = 1'b0;
    at_neg();
    check("t2_full_count", count, 4);
    step();
    rf_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("t2_drain_we", rf_we, 1);
      check("t2_drain_count", count, 4 - i);
      step();
    end
    at_neg();
    check("t2_empty_count", count, 0);
    check("t2_empty_we", rf_we, 0);

    // Continuous push while draining, across pointer wrap
    step();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_addr  = ADDR_W'(i + 1);
      in_data  = 32'hA000 + i;
      exp_q.push_back('{addr: ADDR_W'(i + 1), data: 32'hA000 + i});
      at_neg();
      check("t3_count", count, (i == 0) ? 0 : 1);
      check("t3_we", rf_we, (i == 0) ? 0 : 1);
      step();
    end
    in_valid = 1'b0;
    at_neg();
    check("t3_tail_we", rf_we, 1);
    step();
    at_neg();
    check("t3_done_count", count, 0);
    check("t3_sb_empty", exp_q.size(), 0);

    // Register 0 is accepted but dropped
    step();
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'h5555;
    at_neg();
    check("t4_r0_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    at_neg();
    check("t4_r0_count", count, 0);
    check("t4_r0_we", rf_we, 0);
    check("t4_r0_pend", pend_mask, 0);

    // Duplicate destinations and forwarding of the youngest
    step();
    rf_stall = 1'b1;
    drive_push(5'd7, 32'h11);
    drive_push(5'd7, 32'h22);
    rd_addr = 5'd7;
    at_neg();
    check("t4_dup_count", count, 2);
    check("t4_dup_pend", pend_mask, 32'h0000_0080);
    check("t4_fwd_hit", rd_hit, FWD ? 1 : 0);
    check("t4_fwd_data", rd_data, FWD ? 32'h22 : 0);
    rd_addr = 5'd3;
    #1;
    check("t4_fwd_miss_hit", rd_hit, 0);
    check("t4_fwd_miss_data", rd_data, 0);
    rd_addr = 5'd0;
    #1;
    check("t4_fwd_r0_hit", rd_hit, 0);
    rd_addr = 5'd7;
    step();
    rf_stall = 1'b0;
    at_neg();
    check("t4_pop1_we", rf_we, 1);
    step();
    at_neg();
    check("t4_one_left_count", count, 1);
    check("t4_one_left_pend", pend_mask, 32'h0000_0080);
    check("t4_one_left_fwd", rd_data, FWD ? 32'h22 : 0);
    step();
    at_neg();
    check("t4_cleared_count", count, 0);
    check("t4_cleared_pend", pend_mask, 0);
    check("t4_cleared_hit", rd_hit, 0);
    rd_addr = 5'd0;

    // Flush beats push and pop
    step();
    rf_stall = 1'b1;
    drive_push(5'd10, 32'hB0);
    drive_push(5'd11, 32'hB1);
    drive_push(5'd12, 32'hB2);
    flush = 1'b1; rf_stall = 1'b0;
    in_valid = 1'b1; in_addr = 5'd13; in_data = 32'hB3;
    at_neg();
    check("t5_flush_ready", in_ready, 0);
    check("t5_flush_we", rf_we, 0);
    check("t5_flush_count", count, 3);
    step();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    at_neg();
    check("t5_post_count", count, 0);
    check("t5_post_pend", pend_mask, 0);
    check("t5_post_we", rf_we, 0);

    // Asynchronous reset mid-drain
    step();
    rf_stall = 1'b1;
    drive_push(5'd20, 32'hC0);
    drive_push(5'd21, 32'hC1);
    drive_push(5'd22, 32'hC2);
    rf_stall = 1'b0;
    #1;
    check("t6_pre_we", rf_we, 1);
    check("t6_pre_count", count, 3);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_we", rf_we, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_pend", pend_mask, 0);
    #3;
    rst_n = 1'b1;
    repeat (3) step();
    at_neg();
    check("t6_after_count", count, 0);
    check("t6_after_we", rf_we, 0);

    check("final_sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
